// File: rtl/apb3_master_pkg.sv
// Shared types and constants for the fabric-side APB3 command master.
// The response flags are derived from one error code, so the error causes cannot produce conflicting flags.
package apb3_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int APB_ALIGN_BITS = 2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SLVERR   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_MISALIGN = 2'd3;

  // Returns {err, timeout}.
  function automatic logic [1:0] err_flags(input logic [1:0] code);
    logic [1:0] flags;
    case (code)
      ERR_NONE:     flags = 2'b00;
      ERR_SLVERR:   flags = 2'b10;
      ERR_TIMEOUT:  flags = 2'b11;
      ERR_MISALIGN: flags = 2'b10;
      default:      flags = 2'b10;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/apb3_timeout_ctr.sv
// Counts ACCESS cycles without PREADY and flags the cycle whose increment reaches the limit.
// A limit of 0 disables expiry.
module apb3_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
  localparam logic          ENABLED = 1'(TIMEOUT_CYCLES > 0);

  logic [CW-1:0] cnt_q;

  // Saturating wait-cycle counter, cleared on entry to ACCESS.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else if (clear_i) begin
      cnt_q <= {CW{1'b0}};
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = ENABLED && en_i && (cnt_q == (LIMIT - CW'(1)));

endmodule

// File: rtl/apb3_cmd_master.sv
// Valid/ready command stream to APB3 SETUP/ACCESS initiator with a single outstanding transfer.
// All outputs are registered; a PREADY timeout and misaligned addresses return error responses.
module apb3_cmd_master
  import apb3_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

  logic tmo_clear_s;
  logic tmo_en_s;
  logic tmo_expired_s;
  logic misaligned_s;

  assign tmo_clear_s  = (state_q == ST_SETUP);
  assign tmo_en_s     = (state_q == ST_ACCESS) && !PREADY;
  assign misaligned_s = |CMD_ADDR[APB_ALIGN_BITS-1:0];

  apb3_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clear_i  (tmo_clear_s),
    .en_i     (tmo_en_s),
    .expired_o(tmo_expired_s)
  );

  // Transfer FSM with registered bus and stream outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= {ADDR_WIDTH{1'b0}};
      pwdata_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          // CMD_READY comes up one cycle after reset release.
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (CMD_VALID) begin
            cmd_ready_q <= 1'b0;
            pwrite_q    <= CMD_WRITE;
            paddr_q     <= CMD_ADDR;
            pwdata_q    <= CMD_WDATA;
            if (misaligned_s) begin
              state_q                      <= ST_RESP;
              rsp_valid_q                  <= 1'b1;
              rsp_rdata_q                  <= {DATA_WIDTH{1'b0}};
              {rsp_err_q, rsp_timeout_q}   <= err_flags(ERR_MISALIGN);
            end else begin
              state_q <= ST_SETUP;
              psel_q  <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q                    <= ST_RESP;
            psel_q                     <= 1'b0;
            penable_q                  <= 1'b0;
            rsp_valid_q                <= 1'b1;
            rsp_rdata_q                <= (!pwrite_q && !PSLVERR) ? PRDATA : {DATA_WIDTH{1'b0}};
            {rsp_err_q, rsp_timeout_q} <= err_flags(PSLVERR ? ERR_SLVERR : ERR_NONE);
          end else if (tmo_expired_s) begin
            state_q                    <= ST_RESP;
            psel_q                     <= 1'b0;
            penable_q                  <= 1'b0;
            rsp_valid_q                <= 1'b1;
            rsp_rdata_q                <= {DATA_WIDTH{1'b0}};
            {rsp_err_q, rsp_timeout_q} <= err_flags(ERR_TIMEOUT);
          end else begin
            state_q <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY   = cmd_ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_TIMEOUT = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: doc/apb3_cmd_master.md
Name: apb3_cmd_master

Overview:
- Fabric-side APB3 initiator: converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers toward the CoreAPB3 bus and its slaves (CoreGPIO).
- Returns read data and error status on a valid/ready response stream.
- Single outstanding transfer; programmable PREADY timeout.
- Lets fabric logic exercise APB slaves without the MSS FIC_0 master.

Parameters:
- ADDR_WIDTH, 32, width of CMD_ADDR/PADDR.
- DATA_WIDTH, 32, width of write/read data.
- TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for PREADY; 0 disables timeout.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_WRITE  in  1  1=write, 0=read.
- CMD_ADDR  in  ADDR_WIDTH  byte address.
- CMD_WDATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed when VALID&READY.
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and errors.
- RSP_ERR  out  1  transfer failed (PSLVERR, timeout or misaligned).
- RSP_TIMEOUT  out  1  failure was a timeout.
- PSEL, PENABLE, PWRITE  out  1  APB3 controls.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1  APB slave handshake/error.

Behaviour:
- Clock and reset are fixed: one clock, PCLK; reset PRESET, asynchronous assert, active-high.
- Reset values: all outputs 0 (CMD_READY=0 during reset); state IDLE; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1. On CMD_VALID, register WRITE/ADDR/WDATA.
  - If CMD_ADDR[1:0]!=0: go to RESP with ERR=1, TIMEOUT=0, RDATA=0. No bus cycle.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = registered command. Then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA are held stable through SETUP and ACCESS.
  - On PREADY=1: capture RDATA=PRDATA for reads (0 for writes) and ERR=PSLVERR. If PSLVERR=1, RDATA=0. Go to RESP.
  - PSLVERR is sampled only when PREADY=1.
- Timeout: counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES: go to RESP with ERR=1, TIMEOUT=1, RDATA=0.
  - The ACCESS cycle that sees the timeout drives PSEL/PENABLE low on the next edge; a late PREADY is ignored.
  - PREADY=1 in the same cycle as timeout expiry: PREADY wins (normal completion).
- RESP: PSEL=PENABLE=0, RSP_VALID=1, RSP_* held stable until RSP_READY. Then go to IDLE.
  - CMD_READY=0 in all states except IDLE.
- Zero-wait latency: command accepted at edge N → PSEL rises after N → PENABLE after N+1 → PREADY sampled at N+2 → RSP_VALID after N+2. With RSP_READY=1 the next command is accepted at N+4. Throughput: one transfer per 4 cycles.
- PWDATA is driven with the registered data for reads too; slaves ignore it.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously. The pending command and response are discarded and not replayed.
- Timeout counter width: clog2(TIMEOUT_CYCLES+1), minimum 1; saturates, no wrap.

Decomposition:
- Shared package apb3_master_pkg holds:
  - State enum (IDLE/SETUP/ACCESS/RESP).
  - Constant APB_ALIGN_BITS=2.
  - Error-code localparams.
- One sub-module is natural: apb3_timeout_ctr (clear/enable/expired, parameterised by TIMEOUT_CYCLES). The rest stays in apb3_cmd_master.

Test Plan:
- Write, zero-wait: CMD write addr 0x04 data 0x0000_0003, PREADY=1.
  → PSEL at N+1, PENABLE at N+2, PADDR=0x04, PWDATA=3.
  → RSP_VALID at N+3 with ERR=0, RDATA=0.
- Read, 3 wait states: CMD read 0x90; PREADY low 3 ACCESS cycles, then high with PRDATA=0x0000_0002.
  → PADDR stable throughout; RSP_RDATA=0x2, ERR=0.
- Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0xDEAD_BEEF.
  → RSP_ERR=1, RSP_TIMEOUT=0, RSP_RDATA=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0.
  → PENABLE high for exactly 4 cycles, then PSEL/PENABLE=0, RSP_ERR=1, RSP_TIMEOUT=1.
  → Variant: PREADY=1 on the 4th cycle gives a normal completion.
- Misaligned address and backpressure: CMD addr 0x06.
  → No PSEL ever; RSP_ERR=1.
  → Hold RSP_READY=0 for 5 cycles: RSP stable, CMD_READY=0, a second CMD_VALID is not accepted until after the handshake.
- Reset mid-ACCESS: assert PRESET while PENABLE=1.
  → PSEL/PENABLE/RSP_VALID low immediately.
  → After release: CMD_READY=1 and no response emitted.
